// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_controller
//  Purpose  : Converts the forwarding unit's load-use flag, the I/D cache miss
//             levels and the EX branch resolution into per-pipeline-register
//             stall/flush controls, a PC hold and a redirect-accept pulse.
//             It sequences D-cache miss waits and post-redirect R1 bubbles,
//             and runs a stall watchdog.
//             Register map: bit i of o_stall/o_flush controls R(i+1), where
//             R1=IF/DEC, R2=DEC/EX, R3=EX/MEM, R4=MEM/WB.
//  Ports    : clk, rst              clock, synchronous active-high reset
//             i_lw_hazard           load-use hazard (DEC needs EX load data)
//             i_ic_miss             IF-stage I-cache miss (level)
//             i_dc_miss             MEM-stage D-cache miss (level until fill)
//             i_br_valid            EX holds a resolved branch
//             i_br_mispredict       EX branch mispredicted (qualified)
//             o_pc_stall            hold PC
//             o_stall[3:0]          hold R1..R4
//             o_flush[3:0]          bubble into R1..R4 (overrides stall)
//             o_redirect            PC redirect accepted this cycle
//             o_stall_timeout       sticky watchdog flag
//             o_cnt_*               performance counters
//  Options  : define HAZARD_PERF_CNT_EN to build the saturating performance
//             counters; otherwise the o_cnt_* outputs are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_controller #(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int STALL_TIMEOUT    = 1024,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_lw_hazard,
    input  logic                 i_ic_miss,
    input  logic                 i_dc_miss,
    input  logic                 i_br_valid,
    input  logic                 i_br_mispredict,
    output logic                 o_pc_stall,
    output logic [3:0]           o_stall,
    output logic [3:0]           o_flush,
    output logic                 o_redirect,
    output logic                 o_stall_timeout,
    output logic [CNT_WIDTH-1:0] o_cnt_lw,
    output logic [CNT_WIDTH-1:0] o_cnt_dc,
    output logic [CNT_WIDTH-1:0] o_cnt_ic,
    output logic [CNT_WIDTH-1:0] o_cnt_redir
);

    localparam int                    c_WD_WIDTH = $clog2(STALL_TIMEOUT + 1);
    localparam logic [c_WD_WIDTH-1:0] c_WD_LIMIT = c_WD_WIDTH'(STALL_TIMEOUT);
    localparam logic [3:0]            c_BUBBLES  = 4'(REDIRECT_BUBBLES);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DC_WAIT  = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [3:0]              r_bcnt;
    logic [3:0]              w_next_bcnt;
    logic [c_WD_WIDTH-1:0]   r_wd;
    logic [c_WD_WIDTH-1:0]   w_wd_next;
    logic                    r_timeout;
    logic                    w_mispredict;

    assign w_mispredict = i_br_valid & i_br_mispredict;

    // ------------------------------------------------------------------------
    // Output decode and next-state logic, in priority order:
    // dc_miss > mispredict > lw_hazard > ic_miss > REDIRECT bubbles.
    // ------------------------------------------------------------------------
    always_comb begin
        o_pc_stall   = 1'b0;
        o_stall      = 4'b0000;
        o_flush      = 4'b0000;
        o_redirect   = 1'b0;
        w_next_state = r_state;
        w_next_bcnt  = r_bcnt;

        if (rst) begin
            o_flush = 4'b1111;
        end else if (i_dc_miss) begin
            // Freeze IF..EX, drain a bubble into WB; bcnt is held so any
            // pending redirect bubbles resume after the fill.
            o_pc_stall   = 1'b1;
            o_stall      = 4'b0111;
            o_flush      = 4'b1000;
            w_next_state = ST_DC_WAIT;
        end else if (w_mispredict) begin
            o_redirect  = 1'b1;
            o_flush     = 4'b0011;
            w_next_bcnt = c_BUBBLES;
            w_next_state = (c_BUBBLES != 4'd0) ? ST_REDIRECT : ST_RUN;
        end else begin
            if (i_lw_hazard) begin
                o_pc_stall = 1'b1;
                o_stall    = 4'b0001;
                o_flush    = 4'b0010;
            end else if (i_ic_miss) begin
                o_pc_stall = 1'b1;
                o_flush    = 4'b0001;
            end else if (r_state == ST_REDIRECT) begin
                o_flush = 4'b0001;
            end

            case (r_state)
                ST_DC_WAIT: begin
                    // First cycle after the fill acts as RUN; bubbles
                    // left over from an interrupted redirect resume next.
                    w_next_state = (r_bcnt != 4'd0) ? ST_REDIRECT : ST_RUN;
                end
                ST_REDIRECT: begin
                    if (r_bcnt != 4'd0) begin
                        w_next_bcnt = r_bcnt - 4'd1;
                    end
                    w_next_state = (r_bcnt <= 4'd1) ? ST_RUN : ST_REDIRECT;
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    // Watchdog count of consecutive PC-stall cycles, saturating at the limit.
    always_comb begin
        w_wd_next = '0;
        if (o_pc_stall) begin
            w_wd_next = (r_wd == c_WD_LIMIT) ? r_wd : r_wd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_bcnt    <= 4'd0;
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_bcnt  <= w_next_bcnt;
            r_wd    <= w_wd_next;
            if (o_pc_stall && (w_wd_next == c_WD_LIMIT)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_stall_timeout = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic                 w_apply_lw;
    logic                 w_apply_ic;
    logic [CNT_WIDTH-1:0] r_cnt_lw;
    logic [CNT_WIDTH-1:0] r_cnt_dc;
    logic [CNT_WIDTH-1:0] r_cnt_ic;
    logic [CNT_WIDTH-1:0] r_cnt_redir;

    // Cycles where the lw / ic encodings actually win the priority decode.
    assign w_apply_lw = ~rst & ~i_dc_miss & ~w_mispredict & i_lw_hazard;
    assign w_apply_ic = ~rst & ~i_dc_miss & ~w_mispredict & ~i_lw_hazard & i_ic_miss;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_lw    <= '0;
            r_cnt_dc    <= '0;
            r_cnt_ic    <= '0;
            r_cnt_redir <= '0;
        end else begin
            if (w_apply_lw && (r_cnt_lw != '1)) begin
                r_cnt_lw <= r_cnt_lw + 1'b1;
            end
            if (i_dc_miss && (r_cnt_dc != '1)) begin
                r_cnt_dc <= r_cnt_dc + 1'b1;
            end
            if (w_apply_ic && (r_cnt_ic != '1)) begin
                r_cnt_ic <= r_cnt_ic + 1'b1;
            end
            if (o_redirect && (r_cnt_redir != '1)) begin
                r_cnt_redir <= r_cnt_redir + 1'b1;
            end
        end
    end

    assign o_cnt_lw    = r_cnt_lw;
    assign o_cnt_dc    = r_cnt_dc;
    assign o_cnt_ic    = r_cnt_ic;
    assign o_cnt_redir = r_cnt_redir;
`else
    assign o_cnt_lw    = '0;
    assign o_cnt_dc    = '0;
    assign o_cnt_ic    = '0;
    assign o_cnt_redir = '0;
`endif

endmodule
`default_nettype wire
